// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI4-Lite read-channel bundle (AR + R) with master/slave views
interface axi_rd_arbiter_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_data;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  modport master(output ar_valid, ar_data, r_ready, input ar_ready, r_valid, r_data);
  modport slave(input ar_valid, ar_data, r_ready, output ar_ready, r_valid, r_data);
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master AXI4-Lite read arbiter, one outstanding read at a time
module axi_rd_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_rd_arbiter_if.slave         m0,
  axi_rd_arbiter_if.slave         m1,
  axi_rd_arbiter_if.master        s,
  output logic [1:0]              gnt
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic   gidx, gidx_n, last, last_n;
  logic   in_addr, in_data, ar_hs, r_hs;
  assign in_addr = state == ADDR;
  assign in_data = state == DATA;
  assign s.ar_valid  = in_addr & (gidx ? m1.ar_valid : m0.ar_valid);
  assign s.ar_data   = in_addr ? (gidx ? m1.ar_data : m0.ar_data) : '0;
  assign s.r_ready   = in_data & (gidx ? m1.r_ready : m0.r_ready);
  assign m0.ar_ready = in_addr & ~gidx & s.ar_ready;
  assign m1.ar_ready = in_addr & gidx & s.ar_ready;
  assign m0.r_valid  = in_data & ~gidx & s.r_valid;
  assign m1.r_valid  = in_data & gidx & s.r_valid;
  assign m0.r_data   = (in_data & ~gidx) ? s.r_data : '0;
  assign m1.r_data   = (in_data & gidx) ? s.r_data : '0;
  assign gnt         = (in_addr | in_data) ? {gidx, ~gidx} : 2'b00;
  assign ar_hs       = s.ar_valid & s.ar_ready;
  assign r_hs        = s.r_valid & s.r_ready;
  // state, grant and round-robin history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gidx  <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      gidx  <= gidx_n;
      last  <= last_n;
    end
  end
  // arbitrate in IDLE only; advance on AR then R handshakes
  always_comb begin
    state_n = state;
    gidx_n  = gidx;
    last_n  = last;
    if (state == IDLE && (m0.ar_valid | m1.ar_valid)) begin
      gidx_n  = (m0.ar_valid & m1.ar_valid) ? (FIXED_PRIO ? 1'b0 : ~last) : m1.ar_valid;
      state_n = ADDR;
    end else if (in_addr && ar_hs) begin
      state_n = DATA;
    end else if (in_data && r_hs) begin
      state_n = IDLE;
      last_n  = gidx;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of a round-robin and a fixed-priority arbiter driven in lockstep
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_v = 1'b0, m1_v = 1'b0, m0_rr = 1'b0, m1_rr = 1'b0;
  logic s_arr = 1'b0, s_rv = 1'b0;
  logic [31:0] m0_a = '0, m1_a = '0, s_rd = '0;
  logic [1:0] gnt_rr, gnt_fp;
  int checks = 0;
  int failures = 0;
  axi_rd_arbiter_if m0a(), m1a(), sa(), m0b(), m1b(), sb();
  assign m0a.ar_valid = m0_v;
  assign m0a.ar_data  = m0_a;
  assign m0a.r_ready  = m0_rr;
  assign m1a.ar_valid = m1_v;
  assign m1a.ar_data  = m1_a;
  assign m1a.r_ready  = m1_rr;
  assign sa.ar_ready  = s_arr;
  assign sa.r_valid   = s_rv;
  assign sa.r_data    = s_rd;
  assign m0b.ar_valid = m0_v;
  assign m0b.ar_data  = m0_a;
  assign m0b.r_ready  = m0_rr;
  assign m1b.ar_valid = m1_v;
  assign m1b.ar_data  = m1_a;
  assign m1b.r_ready  = m1_rr;
  assign sb.ar_ready  = s_arr;
  assign sb.r_valid   = s_rv;
  assign sb.r_data    = s_rd;
  axi_rd_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst(rst), .m0(m0a), .m1(m1a), .s(sa), .gnt(gnt_rr));
  axi_rd_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .s(sb), .gnt(gnt_fp));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3;
    chk("rst_gnt_rr", gnt_rr, 0);
    chk("rst_gnt_fp", gnt_fp, 0);
    chk("rst_s_arvalid", sa.ar_valid, 0);
    chk("rst_s_rready", sa.r_ready, 0);
    chk("rst_m0_arready", m0a.ar_ready, 0);
    chk("rst_m1_rdata", m1a.r_data, 0);
    tick;
    tick;
    rst = 1'b0;
    m0_v = 1; m1_v = 1; m0_a = 32'hA0; m1_a = 32'hB0;
    m0_rr = 1; m1_rr = 1; s_arr = 1; s_rv = 1;
    for (int t = 0; t < 4; t++) begin
      s_rd = 32'h100 + t;
      #1;
      chk("rr_idle_gnt", gnt_rr, 0);
      tick;
      chk("rr_gnt", gnt_rr, t[0] ? 2 : 1);
      chk("fp_gnt", gnt_fp, 1);
      chk("rr_s_ardata", sa.ar_data, t[0] ? 32'hB0 : 32'hA0);
      tick;
      chk("rr_rdata", t[0] ? m1a.r_data : m0a.r_data, 32'h100 + t);
      chk("rr_other_rvalid", t[0] ? m0a.r_valid : m1a.r_valid, 0);
      tick;
    end
    m0_v = 0;
    #1;
    tick;
    chk("fp_m1_alone_gnt", gnt_fp, 2);
    chk("rr_m1_alone_gnt", gnt_rr, 2);
    tick;
    tick;
    m1_v = 0; m0_v = 1; m0_a = 32'h1000; s_rd = 32'hDEADBEEF;
    #1;
    chk("single_idle_gnt", gnt_rr, 0);
    chk("single_idle_arvalid", sa.ar_valid, 0);
    tick;
    chk("single_ardata", sa.ar_data, 32'h1000);
    chk("single_gnt", gnt_rr, 1);
    chk("single_m0_arready", m0a.ar_ready, 1);
    chk("single_m1_arready", m1a.ar_ready, 0);
    tick;
    m0_v = 0;
    #1;
    chk("single_m0_rdata", m0a.r_data, 32'hDEADBEEF);
    chk("single_m0_rvalid", m0a.r_valid, 1);
    chk("single_m1_rvalid", m1a.r_valid, 0);
    chk("single_m1_rdata", m1a.r_data, 0);
    chk("single_data_gnt", gnt_rr, 1);
    tick;
    chk("single_done_gnt", gnt_rr, 0);
    chk("single_done_rdata", m0a.r_data, 0);
    m0_v = 1; m1_v = 1; m0_a = 32'hA0; m1_a = 32'hB0; s_arr = 0; s_rv = 0;
    #1;
    tick;
    chk("sbp_gnt", gnt_rr, 2);
    chk("sbp_ardata", sa.ar_data, 32'hB0);
    chk("sbp_arvalid", sa.ar_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("sbp_addr_gnt", gnt_rr, 2);
      chk("sbp_m1_arready", m1a.ar_ready, 0);
      chk("sbp_m0_arready", m0a.ar_ready, 0);
      tick;
    end
    s_arr = 1;
    #1;
    chk("sbp_m1_arready_hi", m1a.ar_ready, 1);
    chk("sbp_m0_arready_lo", m0a.ar_ready, 0);
    tick;
    m1_v = 0; s_arr = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("sbp_data_gnt", gnt_rr, 2);
      chk("sbp_m1_rvalid_wait", m1a.r_valid, 0);
      chk("sbp_m0_rvalid", m0a.r_valid, 0);
      chk("sbp_data_arvalid", sa.ar_valid, 0);
      tick;
    end
    s_rv = 1; s_rd = 32'h1234;
    #1;
    chk("sbp_m1_rdata", m1a.r_data, 32'h1234);
    chk("sbp_m1_rvalid", m1a.r_valid, 1);
    chk("sbp_m0_rvalid_lo", m0a.r_valid, 0);
    chk("sbp_m0_rdata_lo", m0a.r_data, 0);
    tick;
    chk("sbp_idle_gnt", gnt_rr, 0);
    tick;
    chk("sbp_pending_gnt", gnt_rr, 1);
    s_arr = 1;
    #1;
    tick;
    m0_v = 0;
    #1;
    tick;
    chk("sbp_pending_done", gnt_rr, 0);
    m1_v = 1; m1_a = 32'hC0; m1_rr = 0; s_rd = 32'h5555AAAA;
    #1;
    tick;
    chk("mbp_gnt", gnt_rr, 2);
    tick;
    m1_v = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mbp_s_rready", sa.r_ready, 0);
      chk("mbp_gnt_data", gnt_rr, 2);
      chk("mbp_m1_rdata", m1a.r_data, 32'h5555AAAA);
      tick;
    end
    m1_rr = 1;
    #1;
    chk("mbp_s_rready_hi", sa.r_ready, 1);
    tick;
    chk("mbp_done_gnt", gnt_rr, 0);
    m0_v = 1; s_rv = 0;
    #1;
    tick;
    tick;
    m0_v = 0; s_rv = 1; s_rd = 32'hCAFE;
    #1;
    chk("mrst_data_rvalid", m0a.r_valid, 1);
    chk("mrst_data_gnt", gnt_rr, 1);
    #1;
    rst = 1;
    #1;
    chk("mrst_gnt", gnt_rr, 0);
    chk("mrst_m0_rvalid", m0a.r_valid, 0);
    chk("mrst_m0_rdata", m0a.r_data, 0);
    chk("mrst_s_rready", sa.r_ready, 0);
    tick;
    rst = 0; m0_v = 1; m1_v = 1;
    #1;
    tick;
    chk("mrst_tie_rr", gnt_rr, 1);
    chk("mrst_tie_fp", gnt_fp, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master AXI4-Lite read-channel arbiter sharing one slave read port between the core's load/fetch path (master 0) and a second requester such as a debug or DMA unit (master 1). It sits between the masters' AR/R channels and the system read port. It grants one transaction at a time, using round-robin or fixed priority, and forwards address and data combinationally once a master is granted. Write channels do not pass through this block.

## Interface
- FIXED_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = master 0 always wins ties
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_ARvalid  in  1  master 0 read-address valid
- m0_ARdata  in  32  master 0 read address
- m0_ARready  out  1  master 0 read-address ready
- m0_Rvalid  out  1  master 0 read-data valid
- m0_RReady  in  1  master 0 read-data ready
- m0_Rdata  out  32  master 0 read data
- m1_ARvalid  in  1  master 1 read-address valid
- m1_ARdata  in  32  master 1 read address
- m1_ARready  out  1  master 1 read-address ready
- m1_Rvalid  out  1  master 1 read-data valid
- m1_RReady  in  1  master 1 read-data ready
- m1_Rdata  out  32  master 1 read data
- s_ARvalid  out  1  slave read-address valid
- s_ARdata  out  32  slave read address
- s_ARready  in  1  slave read-address ready
- s_Rvalid  in  1  slave read-data valid
- s_RReady  out  1  slave read-data ready
- s_Rdata  in  32  slave read data
- gnt  out  2  one-hot current grant; 00 while IDLE

## Operation
- State machine has three states: IDLE, ADDR, DATA. Registers: state, gidx (1 bit, granted master), last (1 bit, last master served).
- IDLE: if exactly one m*_ARvalid is high, gidx ← that master. If both are high and FIXED_PRIO=0, gidx ← ~last; with FIXED_PRIO=1, gidx ← 0. Any request moves to ADDR at the next edge. With no request, stay in IDLE.
- ADDR: s_ARvalid = m[gidx]_ARvalid, s_ARdata = m[gidx]_ARdata, m[gidx]_ARready = s_ARready. The other master's ARready = 0. When s_ARvalid & s_ARready, move to DATA.
- DATA: m[gidx]_Rvalid = s_Rvalid, s_RReady = m[gidx]_RReady, m[gidx]_Rdata = s_Rdata. The other master's Rvalid = 0 and Rdata = 0. When s_Rvalid & s_RReady, move to IDLE and set last ← gidx.
- Outside their active state: s_ARvalid = 0, s_RReady = 0, and all m*_ARready, m*_Rvalid and m*_Rdata are 0.
- gnt = one-hot(gidx) in ADDR and DATA, 00 in IDLE.
- Only one transaction is outstanding at a time. A new arbitration happens only in IDLE, so a master cannot be re-granted in the same cycle its R handshake completes.
- Masters must hold ARvalid and ARdata until ARready. If a granted master drops ARvalid anyway, the arbiter stays in ADDR with s_ARvalid = 0 and does not re-arbitrate.
- The R response is always routed to gidx; the block does no ID tracking.
- Reset: state ← IDLE, gidx ← 0, last ← 1, so master 0 wins the first tie. Every output is 0 during reset and in IDLE.
- Reset mid-transaction abandons the transfer immediately. The slave must be reset by the same rst.

## Timing
- Arbitration latency: ARvalid sampled high in IDLE at edge k; s_ARvalid is high from after edge k (ADDR state).
- Address phase: one cycle minimum, when s_ARready is already high.
- Data phase: one cycle minimum, when s_Rvalid and RReady are already high.
- Minimum transaction length is 3 cycles (IDLE, ADDR, DATA), so sustained throughput is at most one read per 3 cycles.
- Forwarded paths (ARdata, ARready, Rvalid, Rdata, RReady) are combinational through a gidx mux, with no added register stage.
- The arbitration decision uses only registered state and the current m*_ARvalid. There are no combinational paths from s_* inputs to the grant.

## Test plan
- Single request: m0 requests address 0x0000_1000; slave ARready=1 and Rvalid=1 with Rdata 0xDEADBEEF; m0 RReady=1. Required: s_ARdata=0x1000 one cycle after request, m0_Rdata=0xDEADBEEF, gnt=01, back to IDLE after 3 cycles, m1 outputs stay 0.
- Simultaneous, round-robin (FIXED_PRIO=0): m0 and m1 request continuously, four transactions. Required grant order m0, m1, m0, m1, each completing in 3 cycles.
- Simultaneous, fixed priority (FIXED_PRIO=1): both request continuously. Required: m0 wins every arbitration and m1 is served only when m0_ARvalid=0.
- Slave backpressure: ARready held low for 5 cycles, then Rvalid delayed 4 cycles. Required: stay in ADDR, then DATA; the other master's request stays pending; no handshakes leak to the non-granted master.
- Master backpressure: m1 granted, m1_RReady held low for 3 cycles while s_Rvalid=1. Required: s_RReady=0, state stays DATA, Rdata held stable; completes on the first cycle with RReady=1.
- Reset mid-DATA: assert rst while in DATA. Required: all outputs 0 immediately (asynchronous); after release, state IDLE and the first tie is granted to m0.
